// File: rtl/bpb_commit_queue_pkg.sv
// Shared types and constants for the branch-prediction commit queue.
//   word_t        : 32-bit machine word (PCs, targets)
//   bpb_result_t  : predictor result {taken, destpc}
//   brq_entry_t   : one outstanding branch {pc, hit, pred}
//   BRQ_DEPTH     : default queue depth
//   BRQ_DSLOT_OFS : fall-through offset past the delay slot
package bpb_commit_queue_pkg;

  typedef logic [31:0] word_t;

  typedef struct packed {
    logic  taken;
    word_t destpc;
  } bpb_result_t;

  typedef struct packed {
    word_t       pc;
    logic        hit;
    bpb_result_t pred;
  } brq_entry_t;

  localparam int    BRQ_DEPTH     = 8;
  localparam word_t BRQ_DSLOT_OFS = 32'd8;

  // A predictor miss means fetch went sequential, i.e. predicted not-taken.
  function automatic bpb_result_t brq_eff_pred(brq_entry_t e);
    bpb_result_t r;
    r.taken  = e.hit & e.pred.taken;
    r.destpc = e.pred.destpc;
    return r;
  endfunction

endpackage

// File: rtl/bpb_commit_queue_fifo.sv
// 2-write / 1-read circular buffer of outstanding branches.
//   clk, reset   : clock, async active-high reset
//   wr_en[1:0]   : per-slot write enables (already qualified by the caller)
//   wr_data[1:0] : slot entries; slot 0 is older and lands first
//   rd_en        : pop head
//   flush        : empty the buffer at this edge (overrides push/pop)
//   rd_data      : head entry (combinational)
//   count        : occupied entries
//   push_ready   : at least two entries free
module brq_fifo
  import bpb_commit_queue_pkg::*;
#(
  parameter int DEPTH = BRQ_DEPTH,
  parameter int PTR_W = $clog2(DEPTH)
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic [1:0]           wr_en,
  input  brq_entry_t [1:0]     wr_data,
  input  logic                 rd_en,
  input  logic                 flush,
  output brq_entry_t           rd_data,
  output logic [PTR_W:0]       count,
  output logic                 push_ready
);

  brq_entry_t         mem_q [DEPTH];
  logic [PTR_W-1:0]   head_q, head_d;
  logic [PTR_W-1:0]   tail_q, tail_d;
  logic [PTR_W:0]     count_q, count_d;
  logic [PTR_W:0]     num_wr;
  logic [PTR_W-1:0]   tail_p1;

  assign num_wr  = {{PTR_W{1'b0}}, wr_en[0]} + {{PTR_W{1'b0}}, wr_en[1]};
  assign tail_p1 = tail_q + {{(PTR_W-1){1'b0}}, 1'b1};

  // Storage carries no reset: validity is defined by head/tail/count only.
  always_ff @(posedge clk) begin
    case (wr_en)
      2'b01: mem_q[tail_q] <= wr_data[0];
      2'b10: mem_q[tail_q] <= wr_data[1];
      2'b11: begin
        mem_q[tail_q]  <= wr_data[0];
        mem_q[tail_p1] <= wr_data[1];
      end
      default: ;
    endcase
  end

  always_comb begin
    head_d  = head_q;
    tail_d  = tail_q;
    count_d = count_q;
    if (flush) begin
      head_d  = '0;
      tail_d  = '0;
      count_d = '0;
    end else begin
      if (rd_en) head_d = head_q + {{(PTR_W-1){1'b0}}, 1'b1};
      tail_d  = tail_q + num_wr[PTR_W-1:0];
      count_d = count_q + num_wr - {{PTR_W{1'b0}}, rd_en};
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      head_q  <= '0;
      tail_q  <= '0;
      count_q <= '0;
    end else begin
      head_q  <= head_d;
      tail_q  <= tail_d;
      count_q <= count_d;
    end
  end

  assign rd_data    = mem_q[head_q];
  assign count      = count_q;
  assign push_ready = (count_q <= (PTR_W+1)'(DEPTH - 2));

endmodule

// File: rtl/bpb_commit_queue.sv
// In-order queue of outstanding branch predictions between fetch and execute.
// Fetch pushes up to two predictions per cycle; each branch resolved by
// execute pops the head, trains the predictor and, on a mispredict, redirects
// fetch and flushes every younger (wrong-path) entry.
// Optional macro BRQ_PERF_CNT_EN: enables saturating branch/mispredict counters;
// when undefined the counter outputs are tied to zero.
// Ports:
//   clk, reset                  : clock, async active-high reset
//   stall                       : freezes push and resolve
//   push_valid/pc/hit/pred[1:0] : fetch predictions, slot 0 older
//   push_ready                  : >=2 entries free
//   res_valid/taken/target      : execute resolution of the oldest branch
//   pc_commit, wen, destpc_commit : predictor training (registered)
//   redirect_valid, redirect_pc : mispredict redirect (registered)
//   count                       : occupied entries
//   branch_cnt, mispred_cnt     : perf counters
module bpb_commit_queue
  import bpb_commit_queue_pkg::*;
#(
  parameter int DEPTH = BRQ_DEPTH,
  parameter int PTR_W = $clog2(DEPTH)
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               stall,
  input  logic [1:0]         push_valid,
  input  logic [1:0][31:0]   push_pc,
  input  logic [1:0]         push_hit,
  input  bpb_result_t [1:0]  push_pred,
  output logic               push_ready,
  input  logic               res_valid,
  input  logic               res_taken,
  input  logic [31:0]        res_target,
  output logic [31:0]        pc_commit,
  output logic               wen,
  output bpb_result_t        destpc_commit,
  output logic               redirect_valid,
  output logic [31:0]        redirect_pc,
  output logic [PTR_W:0]     count,
  output logic [31:0]        branch_cnt,
  output logic [31:0]        mispred_cnt
);

  brq_entry_t        head;
  brq_entry_t [1:0]  wr_data;
  bpb_result_t       eff;
  logic [1:0]        wr_en;
  logic              do_res;
  logic              mispredict;

  logic        wen_q,    wen_d;
  logic        redir_q,  redir_d;
  word_t       pc_q,     pc_d;
  bpb_result_t dest_q,   dest_d;
  word_t       rpc_q,    rpc_d;

  assign do_res     = !stall && res_valid && (count != '0);
  assign eff        = brq_eff_pred(head);
  assign mispredict = do_res &&
                      ((eff.taken != res_taken) ||
                       (res_taken && (eff.destpc != res_target)));

  // Same-edge pushes behind a mispredict are wrong-path and never enter.
  assign wr_en = (!stall && push_ready && !mispredict) ? push_valid : 2'b00;

  always_comb begin
    for (int i = 0; i < 2; i++) begin
      wr_data[i].pc   = push_pc[i];
      wr_data[i].hit  = push_hit[i];
      wr_data[i].pred = push_pred[i];
    end
  end

  brq_fifo #(.DEPTH(DEPTH), .PTR_W(PTR_W)) u_fifo (
    .clk        (clk),
    .reset      (reset),
    .wr_en      (wr_en),
    .wr_data    (wr_data),
    .rd_en      (do_res),
    .flush      (mispredict),
    .rd_data    (head),
    .count      (count),
    .push_ready (push_ready)
  );

  // Training/redirect outputs; data holds between resolves, strobes are
  // single-cycle pulses (a stalled cycle drops them).
  always_comb begin
    wen_d   = 1'b0;
    redir_d = 1'b0;
    pc_d    = pc_q;
    dest_d  = dest_q;
    rpc_d   = rpc_q;
    if (do_res) begin
      wen_d         = 1'b1;
      pc_d          = head.pc;
      dest_d.taken  = res_taken;
      dest_d.destpc = res_taken ? res_target : head.pred.destpc;
      if (mispredict) begin
        redir_d = 1'b1;
        rpc_d   = res_taken ? res_target : head.pc + BRQ_DSLOT_OFS;
      end
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      wen_q   <= 1'b0;
      redir_q <= 1'b0;
      pc_q    <= '0;
      dest_q  <= '0;
      rpc_q   <= '0;
    end else begin
      wen_q   <= wen_d;
      redir_q <= redir_d;
      pc_q    <= pc_d;
      dest_q  <= dest_d;
      rpc_q   <= rpc_d;
    end
  end

  assign wen            = wen_q;
  assign redirect_valid = redir_q;
  assign pc_commit      = pc_q;
  assign destpc_commit  = dest_q;
  assign redirect_pc    = rpc_q;

`ifdef BRQ_PERF_CNT_EN
  logic [31:0] bcnt_q, bcnt_d;
  logic [31:0] mcnt_q, mcnt_d;

  always_comb begin
    bcnt_d = bcnt_q;
    mcnt_d = mcnt_q;
    if (do_res && (bcnt_q != '1))     bcnt_d = bcnt_q + 32'd1;
    if (mispredict && (mcnt_q != '1)) mcnt_d = mcnt_q + 32'd1;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      bcnt_q <= '0;
      mcnt_q <= '0;
    end else begin
      bcnt_q <= bcnt_d;
      mcnt_q <= mcnt_d;
    end
  end

  assign branch_cnt  = bcnt_q;
  assign mispred_cnt = mcnt_q;
`else
  assign branch_cnt  = '0;
  assign mispred_cnt = '0;
`endif

  // Producer protocol checks.
  a_push_overflow: assert property (@(posedge clk) disable iff (reset)
    !(!stall && !push_ready && (push_valid != 2'b00)));
  a_resolve_empty: assert property (@(posedge clk) disable iff (reset)
    !(!stall && res_valid && (count == '0)));

endmodule

// File: tb/tb_bpb_commit_queue.sv
module tb_bpb_commit_queue;
  import bpb_commit_queue_pkg::*;

  localparam int DEPTH = 8;
  localparam int PTR_W = 3;

  logic              clk = 1'b0;
  logic              reset;
  logic              stall;
  logic [1:0]        push_valid;
  logic [1:0][31:0]  push_pc;
  logic [1:0]        push_hit;
  bpb_result_t [1:0] push_pred;
  logic              push_ready;
  logic              res_valid;
  logic              res_taken;
  logic [31:0]       res_target;
  logic [31:0]       pc_commit;
  logic              wen;
  bpb_result_t       destpc_commit;
  logic              redirect_valid;
  logic [31:0]       redirect_pc;
  logic [PTR_W:0]    count;
  logic [31:0]       branch_cnt;
  logic [31:0]       mispred_cnt;

  bpb_commit_queue #(.DEPTH(DEPTH), .PTR_W(PTR_W)) dut (
    .clk(clk), .reset(reset), .stall(stall),
    .push_valid(push_valid), .push_pc(push_pc), .push_hit(push_hit),
    .push_pred(push_pred), .push_ready(push_ready),
    .res_valid(res_valid), .res_taken(res_taken), .res_target(res_target),
    .pc_commit(pc_commit), .wen(wen), .destpc_commit(destpc_commit),
    .redirect_valid(redirect_valid), .redirect_pc(redirect_pc),
    .count(count), .branch_cnt(branch_cnt), .mispred_cnt(mispred_cnt)
  );

  always #5 clk = ~clk;

  // Reference model: a queue of branches and the expected output registers.
  typedef struct {
    logic [31:0] pc;
    logic        hit;
    logic        pt;
    logic [31:0] pd;
  } ment_t;

  ment_t       mq[$];
  logic        e_wen, e_redir, e_dtaken;
  logic [31:0] e_pc, e_ddest, e_rpc;
  int unsigned e_bcnt, e_mcnt;
  int unsigned nvec = 0, nmis = 0;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    nvec++;
    if (obs !== exp) begin
      nmis++;
      $display("FAIL %s: got %0h want %0h (t=%0t)", tag, obs, exp, $time);
    end
  endtask

  task automatic model_clear();
    mq.delete();
    e_wen = 0; e_redir = 0; e_dtaken = 0;
    e_pc = 0; e_ddest = 0; e_rpc = 0;
    e_bcnt = 0; e_mcnt = 0;
  endtask

  // Applies one clock edge of the rules to the model, from current inputs.
  task automatic model_edge();
    bit    ready, mis;
    ment_t e, n;
    ready = (mq.size() <= DEPTH - 2);
    e_wen = 0; e_redir = 0;
    if (stall) return;
    mis = 0;
    if (res_valid && mq.size() != 0) begin
      e = mq.pop_front();
      if (res_taken) mis = !(e.hit && e.pt && e.pd == res_target);
      else           mis = (e.hit && e.pt);
      e_wen = 1; e_pc = e.pc; e_dtaken = res_taken;
      e_ddest = res_taken ? res_target : e.pd;
      if (e_bcnt != 32'hFFFF_FFFF) e_bcnt++;
      if (mis) begin
        e_redir = 1;
        e_rpc = res_taken ? res_target : e.pc + 32'd8;
        if (e_mcnt != 32'hFFFF_FFFF) e_mcnt++;
        mq.delete();
      end
    end
    if (!mis && ready) begin
      for (int s = 0; s < 2; s++) if (push_valid[s]) begin
        n.pc = push_pc[s]; n.hit = push_hit[s];
        n.pt = push_pred[s].taken; n.pd = push_pred[s].destpc;
        mq.push_back(n);
      end
    end
  endtask

  task automatic check_all();
    chk("wen", 64'(wen), 64'(e_wen));
    chk("redirect_valid", 64'(redirect_valid), 64'(e_redir));
    chk("pc_commit", 64'(pc_commit), 64'(e_pc));
    chk("dest_taken", 64'(destpc_commit.taken), 64'(e_dtaken));
    chk("dest_pc", 64'(destpc_commit.destpc), 64'(e_ddest));
    chk("redirect_pc", 64'(redirect_pc), 64'(e_rpc));
    chk("count", 64'(count), 64'(mq.size()));
    chk("push_ready", 64'(push_ready), 64'(mq.size() <= DEPTH - 2));
`ifdef BRQ_PERF_CNT_EN
    chk("branch_cnt", 64'(branch_cnt), 64'(e_bcnt));
    chk("mispred_cnt", 64'(mispred_cnt), 64'(e_mcnt));
`else
    chk("branch_cnt", 64'(branch_cnt), 64'd0);
    chk("mispred_cnt", 64'(mispred_cnt), 64'd0);
`endif
  endtask

  task automatic step();
    model_edge();
    @(posedge clk);
    #1;
    check_all();
  endtask

  task automatic clr();
    stall = 0; push_valid = 0; push_pc = '0; push_hit = 0; push_pred = '0;
    res_valid = 0; res_taken = 0; res_target = 0;
  endtask

  task automatic set_push(input int s, input logic [31:0] pc, input logic hit,
                          input logic t, input logic [31:0] d);
    push_valid[s] = 1; push_pc[s] = pc; push_hit[s] = hit;
    push_pred[s].taken = t; push_pred[s].destpc = d;
  endtask

  // Resolve the model's head exactly as predicted (no mispredict).
  task automatic res_correct();
    res_valid  = 1;
    res_taken  = mq[0].hit && mq[0].pt;
    res_target = mq[0].pd;
  endtask

  task automatic rand_push(input int s);
    set_push(s, $urandom & 32'hFFFF_FFFC, 1'($urandom), 1'($urandom),
             $urandom & 32'hFFFF_FFFC);
  endtask

  task automatic do_reset();
    #2 reset = 1;
    #1;
    model_clear();
    check_all();
    #1 reset = 0;
  endtask

  initial begin
    int fill;
    reset = 1;
    clr();
    model_clear();
    #1 check_all();
    #2 reset = 0;

    // 1: hit, correct taken prediction
    set_push(0, 32'h100, 1, 1, 32'h200); step();
    clr(); res_valid = 1; res_taken = 1; res_target = 32'h200; step();
    chk("t1_pc", 64'(pc_commit), 64'h100);
    clr(); step();

    // 2: miss, actually taken
    set_push(0, 32'h300, 0, 0, 32'h0); step();
    clr(); res_valid = 1; res_taken = 1; res_target = 32'h400; step();
    chk("t2_rpc", 64'(redirect_pc), 64'h400);
    clr(); step();

    // 3: predicted taken, actually not; same-cycle push is wrong-path
    set_push(0, 32'h104, 1, 1, 32'h500); step();
    clr(); res_valid = 1; res_taken = 0;
    set_push(0, 32'h600, 1, 0, 0); set_push(1, 32'h604, 1, 0, 0); step();
    chk("t3_rpc", 64'(redirect_pc), 64'h10C);
    chk("t3_count", 64'(count), 64'd0);
    clr(); step();
`ifdef BRQ_PERF_CNT_EN
    chk("t3_bcnt", 64'(branch_cnt), 64'd3);
    chk("t3_mcnt", 64'(mispred_cnt), 64'd2);
`endif

    // 4: fill to count=7, then steady push+resolve across pointer wrap
    rand_push(0); step();
    fill = 0;
    while (mq.size() <= DEPTH - 2 && fill < 20) begin
      clr(); rand_push(0); rand_push(1); step(); fill++;
    end
    chk("t4_full", 64'(count), 64'd7);
    clr(); res_correct(); step();
    for (int i = 0; i < 20; i++) begin
      clr(); rand_push(0); res_correct(); step();
    end

    // 5: stall holds a resolve; exactly one wen after release
    for (int i = 0; i < 3; i++) begin
      clr(); stall = 1; res_correct(); step();
    end
    clr(); res_correct(); step();
    chk("t5_wen", 64'(wen), 64'd1);
    clr(); step();

    // 6: async reset with entries in flight
    chk("t6_pre", 64'(count), 64'd5);
    do_reset();
    clr(); step();

    // Random traffic
    for (int i = 0; i < 400; i++) begin
      clr();
      stall = ($urandom_range(0, 7) == 0);
      if (mq.size() <= DEPTH - 2 && $urandom_range(0, 2) != 0) begin
        case ($urandom_range(0, 2))
          0: rand_push(0);
          1: rand_push(1);
          default: begin rand_push(0); rand_push(1); end
        endcase
      end
      if (mq.size() != 0 && $urandom_range(0, 1) != 0) begin
        res_correct();
        if ($urandom_range(0, 3) == 0) begin
          res_taken  = 1'($urandom);
          res_target = ($urandom_range(0, 1) != 0) ? mq[0].pd : ($urandom & 32'hFFFF_FFFC);
        end
      end
      step();
      if (i == 250) do_reset();
    end

    $display("== %0d vectors applied, %0d miscompares ==", nvec, nmis);
    $finish;
  end

endmodule
